// File: rtl/prf_multiport_rdy.sv
// ---------------------------------------------------------------------------
// prf_multiport_rdy
//
// Physical register file with an integrated per-register ready table
// (scoreboard) shared by rename, the issue queues and writeback.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   rd_en/rd_addr     NUM_RD read requests; rd_data/rd_valid arrive one
//                     cycle later (rd_data holds when the port is idle)
//   wr_en/wr_addr/wr_data
//                     NUM_WR writeback ports; a write also marks the
//                     destination ready
//   chk_addr/chk_rdy  NUM_CHK combinational ready lookups
//   alloc_en/alloc_addr
//                     NUM_ALLOC rename ports that mark a destination
//                     not ready
//   rdy_flush         recovery: every ready bit is set at the edge
//   err_wr_conflict   sticky flag, two write ports hit one index in a cycle
// ---------------------------------------------------------------------------
module prf_multiport_rdy #(
    parameter int DATA_W    = 32,
    parameter int NUM_PREGS = 128,
    parameter int PREG_W    = 7,
    parameter int NUM_RD    = 4,
    parameter int NUM_WR    = 2,
    parameter int NUM_CHK   = 6,
    parameter int NUM_ALLOC = 3,
    parameter int BYPASS    = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_RD-1:0]           rd_en,
    input  logic [NUM_RD*PREG_W-1:0]    rd_addr,
    output logic [NUM_RD*DATA_W-1:0]    rd_data,
    output logic [NUM_RD-1:0]           rd_valid,
    input  logic [NUM_WR-1:0]           wr_en,
    input  logic [NUM_WR*PREG_W-1:0]    wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]    wr_data,
    input  logic [NUM_CHK*PREG_W-1:0]   chk_addr,
    output logic [NUM_CHK-1:0]          chk_rdy,
    input  logic [NUM_ALLOC-1:0]        alloc_en,
    input  logic [NUM_ALLOC*PREG_W-1:0] alloc_addr,
    input  logic                        rdy_flush,
    output logic                        err_wr_conflict
);

    logic [DATA_W-1:0]         regs [NUM_PREGS];
    logic [NUM_PREGS-1:0]      ready;
    logic [NUM_WR-1:0]         wr_ok;
    logic [NUM_ALLOC-1:0]      alloc_ok;
    logic [NUM_RD*DATA_W-1:0]  rd_next;
    logic                      wr_conflict;

    // Index 0 is hardwired and indices past the array do not exist, so
    // neither may be modified.
    function automatic logic idx_live(input logic [PREG_W-1:0] a);
        return (a != '0) && (int'(a) < NUM_PREGS);
    endfunction

    // Value a read port would capture this cycle. Later write ports
    // override earlier ones so the highest-numbered port wins.
    function automatic logic [DATA_W-1:0] read_value(input logic [PREG_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (idx_live(a)) begin
            v = regs[a];
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_ok[j] && wr_addr[j*PREG_W +: PREG_W] == a)
                        v = wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
        return v;
    endfunction

    // Ready lookup against the pre-edge table; same-cycle allocs and
    // flushes are deliberately invisible here.
    function automatic logic check_ready(input logic [PREG_W-1:0] a);
        logic r;
        if (a == '0)
            r = 1'b1;
        else if (!idx_live(a))
            r = 1'b0;
        else begin
            r = ready[a];
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_ok[j] && wr_addr[j*PREG_W +: PREG_W] == a)
                        r = 1'b1;
                end
            end
        end
        return r;
    endfunction

    // Qualify write and alloc requests once so every consumer agrees.
    always_comb begin
        for (int j = 0; j < NUM_WR; j++)
            wr_ok[j] = wr_en[j] && idx_live(wr_addr[j*PREG_W +: PREG_W]);
        for (int n = 0; n < NUM_ALLOC; n++)
            alloc_ok[n] = alloc_en[n] && idx_live(alloc_addr[n*PREG_W +: PREG_W]);
    end

    // Any pair of enabled write ports targeting the same nonzero index.
    always_comb begin
        wr_conflict = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            for (int m = j + 1; m < NUM_WR; m++) begin
                if (wr_en[j] && wr_en[m] &&
                    wr_addr[j*PREG_W +: PREG_W] == wr_addr[m*PREG_W +: PREG_W] &&
                    wr_addr[j*PREG_W +: PREG_W] != '0)
                    wr_conflict = 1'b1;
            end
        end
    end

    // Read data and ready-check results for this cycle.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_RD; i++)
            rd_next[i*DATA_W +: DATA_W] = read_value(rd_addr[i*PREG_W +: PREG_W]);
        chk_rdy = '0;
        for (int k = 0; k < NUM_CHK; k++)
            chk_rdy[k] = check_ready(chk_addr[k*PREG_W +: PREG_W]);
    end

    // Register array; loop order lets the highest write port win a conflict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_PREGS; k++)
                regs[k] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_ok[j])
                    regs[wr_addr[j*PREG_W +: PREG_W]] <= wr_data[j*DATA_W +: DATA_W];
            end
        end
    end

    // Ready table. Allocs are applied after writes so alloc wins a
    // same-index collision; flush overrides everything and drops allocs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready <= '1;
        end else if (rdy_flush) begin
            ready <= '1;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_ok[j])
                    ready[wr_addr[j*PREG_W +: PREG_W]] <= 1'b1;
            end
            for (int n = 0; n < NUM_ALLOC; n++) begin
                if (alloc_ok[n])
                    ready[alloc_addr[n*PREG_W +: PREG_W]] <= 1'b0;
            end
        end
    end

    // Registered read ports; idle ports keep their last data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= '0;
        end else begin
            rd_valid <= rd_en;
            for (int i = 0; i < NUM_RD; i++) begin
                if (rd_en[i])
                    rd_data[i*DATA_W +: DATA_W] <= rd_next[i*DATA_W +: DATA_W];
            end
        end
    end

    // Sticky conflict flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_wr_conflict <= 1'b0;
        else if (wr_conflict)
            err_wr_conflict <= 1'b1;
    end

endmodule

// File: tb/tb_prf_multiport_rdy.sv
// ---------------------------------------------------------------------------
// tb_prf_multiport_rdy
//
// Directed bench for prf_multiport_rdy. Two instances share all inputs:
// dut (BYPASS=1) and dut_nb (BYPASS=0), so bypass-dependent behaviour is
// compared side by side. Inputs change 1 ns after a rising edge; outputs
// are sampled at least 1 ns after that.
// ---------------------------------------------------------------------------
module tb_prf_multiport_rdy;

    localparam int DW = 32;
    localparam int PW = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    rd_en;
    logic [27:0]   rd_addr;
    logic [127:0]  rd_data, rd_data_nb;
    logic [3:0]    rd_valid, rd_valid_nb;
    logic [1:0]    wr_en;
    logic [13:0]   wr_addr;
    logic [63:0]   wr_data;
    logic [41:0]   chk_addr;
    logic [5:0]    chk_rdy, chk_rdy_nb;
    logic [2:0]    alloc_en;
    logic [20:0]   alloc_addr;
    logic          rdy_flush;
    logic          err, err_nb;

    int total = 0;
    int bad   = 0;

    prf_multiport_rdy #(.BYPASS(1)) dut (
        .clk(clk), .reset(reset),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .chk_addr(chk_addr), .chk_rdy(chk_rdy),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .rdy_flush(rdy_flush), .err_wr_conflict(err)
    );

    prf_multiport_rdy #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_valid(rd_valid_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .chk_addr(chk_addr), .chk_rdy(chk_rdy_nb),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .rdy_flush(rdy_flush), .err_wr_conflict(err_nb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = '0; wr_en = '0; alloc_en = '0; rdy_flush = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_en[p] = 1'b1;
        rd_addr[p*PW +: PW] = 7'(a);
    endtask

    task automatic set_wr(input int p, input int a, input logic [31:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*PW +: PW] = 7'(a);
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic set_alloc(input int p, input int a);
        alloc_en[p] = 1'b1;
        alloc_addr[p*PW +: PW] = 7'(a);
    endtask

    task automatic set_chk(input int p, input int a);
        chk_addr[p*PW +: PW] = 7'(a);
    endtask

    initial begin
        reset = 1'b1;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        chk_addr = '0; alloc_addr = '0;
        idle();

        // 1: reset state and read-back of a cleared register
        step(); step();
        check("rst_rd_valid", 64'(rd_valid), 64'h0);
        check("rst_rd_data", 64'(rd_data), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        reset = 1'b0;
        for (int idx = 0; idx < 128; idx++) begin
            set_chk(idx % 6, idx);
            #1;
            check($sformatf("rst_chk_%0d", idx), 64'(chk_rdy[idx % 6]), 64'h1);
        end
        step();
        set_rd(0, 5);
        step();
        idle();
        check("t1_rd_valid", 64'(rd_valid), 64'h1);
        check("t1_rd_data", 64'(rd_data[0 +: DW]), 64'h0);

        // 2: alloc / write lifecycle
        set_alloc(0, 9);
        set_chk(0, 9);
        #1;
        check("t2_chk_pre_alloc", 64'(chk_rdy[0]), 64'h1);
        step();
        idle();
        #1;
        check("t2_chk_after_alloc", 64'(chk_rdy[0]), 64'h0);
        set_wr(1, 9, 32'hDEADBEEF);
        #1;
        check("t2_chk_bypass", 64'(chk_rdy[0]), 64'h1);
        check("t2_chk_nobypass", 64'(chk_rdy_nb[0]), 64'h0);
        step();
        idle();
        #1;
        check("t2_chk_after_wr", 64'(chk_rdy[0]), 64'h1);
        check("t2_chk_after_wr_nb", 64'(chk_rdy_nb[0]), 64'h1);
        set_rd(2, 9);
        step();
        idle();
        check("t2_rd_valid", 64'(rd_valid), 64'h4);
        check("t2_rd_data", 64'(rd_data[2*DW +: DW]), 64'hDEADBEEF);

        // 3: write-to-read bypass versus no bypass
        set_wr(0, 20, 32'h55);
        step();
        idle();
        set_wr(0, 20, 32'h1234);
        set_rd(1, 20);
        step();
        idle();
        check("t3_bypass", 64'(rd_data[DW +: DW]), 64'h1234);
        check("t3_nobypass", 64'(rd_data_nb[DW +: DW]), 64'h55);
        step();
        check("t3_idle_valid", 64'(rd_valid), 64'h0);
        check("t3_hold", 64'(rd_data_nb[DW +: DW]), 64'h55);
        set_rd(1, 20);
        step();
        idle();
        check("t3_repeat_nb", 64'(rd_data_nb[DW +: DW]), 64'h1234);
        check("t3_err_clear", 64'(err), 64'h0);

        // 4: write-port conflict, highest port wins, sticky flag
        set_wr(0, 7, 32'hA);
        set_wr(1, 7, 32'hB);
        set_rd(3, 7);
        step();
        idle();
        check("t4_err", 64'(err), 64'h1);
        check("t4_bypass_wins", 64'(rd_data[3*DW +: DW]), 64'hB);
        check("t4_nobypass_old", 64'(rd_data_nb[3*DW +: DW]), 64'h0);
        set_rd(3, 7);
        step();
        idle();
        check("t4_reg7", 64'(rd_data[3*DW +: DW]), 64'hB);
        check("t4_reg7_nb", 64'(rd_data_nb[3*DW +: DW]), 64'hB);
        for (int c = 0; c < 10; c++) step();
        check("t4_err_sticky", 64'(err), 64'h1);
        check("t4_err_sticky_nb", 64'(err_nb), 64'h1);

        // 5: preg 0 and alloc/write collision
        set_wr(0, 0, 32'hFF);
        set_alloc(0, 0);
        set_wr(1, 12, 32'h77);
        set_alloc(1, 12);
        set_rd(0, 0);
        set_chk(1, 0);
        #1;
        check("t5_chk0_same", 64'(chk_rdy[1]), 64'h1);
        step();
        idle();
        check("t5_rd0_bypass", 64'(rd_data[0 +: DW]), 64'h0);
        set_rd(0, 0);
        set_rd(1, 12);
        set_chk(0, 0);
        set_chk(1, 12);
        #1;
        check("t5_chk0", 64'(chk_rdy[0]), 64'h1);
        check("t5_chk12", 64'(chk_rdy[1]), 64'h0);
        step();
        idle();
        check("t5_rd0", 64'(rd_data[0 +: DW]), 64'h0);
        check("t5_rd12", 64'(rd_data[DW +: DW]), 64'h77);

        // 6: flush recovery, then reset mid-read
        set_alloc(0, 30);
        set_alloc(1, 31);
        set_alloc(2, 32);
        step();
        idle();
        set_chk(0, 30); set_chk(1, 31); set_chk(2, 32); set_chk(3, 40);
        #1;
        check("t6_alloc_notrdy", 64'(chk_rdy[3:0]), 64'h8);
        rdy_flush = 1'b1;
        set_alloc(0, 40);
        #1;
        check("t6_flush_cycle", 64'(chk_rdy[3:0]), 64'h8);
        step();
        idle();
        #1;
        check("t6_after_flush", 64'(chk_rdy[3:0]), 64'hF);
        set_rd(0, 9);
        step();
        check("t6_pre_rst_valid", 64'(rd_valid[0]), 64'h1);
        check("t6_pre_rst_data", 64'(rd_data[0 +: DW]), 64'hDEADBEEF);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_valid", 64'(rd_valid), 64'h0);
        check("t6_rst_data", 64'(rd_data), 64'h0);
        check("t6_rst_err", 64'(err), 64'h0);
        idle();
        step();
        reset = 1'b0;
        step();
        check("t6_post_rst_valid", 64'(rd_valid), 64'h0);
        set_rd(0, 9);
        step();
        idle();
        check("t6_post_rst_data", 64'(rd_data[0 +: DW]), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
